// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled start/data/parity/stop decoding feeding a show-ahead
// receive FIFO, with sticky error flags and registered active-low RTS flow control.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 1,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RTS_THRESH = FIFO_DEPTH - 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baud_tick,
  input  logic                          uart_rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          uart_rts,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HalfLast  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FullLast  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DataLast  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] StopLast  = BW'(STOP_BITS - 1);
  localparam logic [FW-1:0] FullLevel = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] RtsLevel  = FW'(RTS_THRESH);
  localparam logic          OddParity = (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  // Input synchronizer
  logic rxd_meta_q, rxd_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Receive FSM
  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 tick_last;

  // START samples at mid-bit, every later state samples one full bit period apart.
  assign tick_last = (state_q == StStart) ? (tick_cnt_q == HalfLast) : (tick_cnt_q == FullLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    if (baud_tick) begin
      tick_cnt_d = tick_last ? '0 : tick_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
          if (!rxd_sync_q) state_d = StStart;
        end
        StStart: begin
          if (tick_last) state_d = rxd_sync_q ? StIdle : StData;
        end
        StData: begin
          if (tick_last) begin
            shift_d = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DataLast) begin
              bit_cnt_d = '0;
              state_d   = (PARITY != 0) ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (tick_last) begin
            par_bad_d = (^{shift_q, rxd_sync_q}) != OddParity;
            state_d   = StStop;
          end
        end
        StStop: begin
          if (tick_last) begin
            if (!rxd_sync_q) begin
              state_d = StBreak;
            end else if (bit_cnt_q == StopLast) begin
              state_d = StIdle;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        StBreak: begin
          tick_cnt_d = '0;
          if (rxd_sync_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame outcome strobes, all qualified by the stop-bit sampling tick
  logic stop_sample, last_stop, wr_req, perr_evt, ferr_evt;

  always_comb begin
    stop_sample = baud_tick && tick_last && (state_q == StStop);
    ferr_evt    = stop_sample && !rxd_sync_q;
    last_stop   = stop_sample && rxd_sync_q && (bit_cnt_q == StopLast);
    wr_req      = last_stop && !par_bad_q;
    perr_evt    = last_stop && par_bad_q;
  end

  // Receive FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 empty, full, do_rd, do_wr, ovr_evt;

  always_comb begin
    empty   = (fill_q == '0);
    full    = (fill_q == FullLevel);
    do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    do_wr   = wr_req && (!full || do_rd);
    ovr_evt = wr_req && full && !do_rd;
    fill_d  = fill_q;
    unique case ({do_wr, do_rd})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q <= fill_d;
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr_q];
  assign fill     = fill_q;

  // Flow control and sticky flags; a new error event beats a simultaneous clear.
  logic rts_q, perr_q, ferr_q, ovr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rts_q  <= 1'b1;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      rts_q  <= (fill_q >= RtsLevel);
      perr_q <= perr_evt | (perr_q & ~clr_err);
      ferr_q <= ferr_evt | (ferr_q & ~clr_err);
      ovr_q  <= ovr_evt  | (ovr_q  & ~clr_err);
    end
  end

  assign uart_rts   = rts_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at default parameters: directed frame table,
// multi-cycle corner sequences and randomized frames against a queue-based model.
module tb_uart_rx_fifo;

  localparam int CPB = 64;  // clocks per bit: 16 ticks, one tick every 4 clocks

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fill;
  logic       uart_rts, parity_err, frame_err, overrun;

  int total = 0;
  int bad = 0;
  logic [7:0] model_q[$];

  uart_rx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .uart_rxd   (uart_rxd),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fill       (fill),
    .uart_rts   (uart_rts),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       exp_wr;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      uart_rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bits(frame_bits(d, p, s), 11);
    repeat (CPB / 2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    e = model_q.pop_front();
    check($sformatf("%s_valid", name), rd_valid, 1);
    check($sformatf("%s_data", name), rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Model: a frame is judged purely from what was put on the wire.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s,
                             output logic e_perr, output logic e_ferr, output logic e_ovr);
    e_perr = 1'b0;
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    if (!s) e_ferr = 1'b1;
    else if ((^{d, p}) != 1'b0) e_perr = 1'b1;
    else if (model_q.size() >= 16) e_ovr = 1'b1;
    else model_q.push_back(d);
  endtask

  initial begin
    logic e_perr, e_ferr, e_ovr;
    logic [7:0] d, first;
    logic p, s;

    vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, exp_wr: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{d: 8'h3C, p: 1'b1, s: 1'b1, exp_wr: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{d: 8'h01, p: 1'b1, s: 1'b1, exp_wr: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{d: 8'h01, p: 1'b0, s: 1'b1, exp_wr: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{d: 8'hFF, p: 1'b0, s: 1'b1, exp_wr: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[5] = '{d: 8'h00, p: 1'b0, s: 1'b0, exp_wr: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[6] = '{d: 8'h55, p: 1'b0, s: 1'b1, exp_wr: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fill", fill, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_flags", {parity_err, frame_err, overrun}, 0);
    check("rst_rts", uart_rts, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rts_after_release", uart_rts, 0);

    // Read while empty is ignored
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    check("empty_rd_fill", fill, 0);
    check("empty_rd_valid", rd_valid, 0);

    // Directed frame table
    for (int i = 0; i < 7; i++) begin
      pulse_clr();
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s);
      check($sformatf("vec%0d_fill", i), fill, {4'd0, vecs[i].exp_wr});
      check($sformatf("vec%0d_perr", i), parity_err, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), overrun, 0);
      if (vecs[i].exp_wr) begin
        model_q.push_back(vecs[i].d);
        pop_check($sformatf("vec%0d", i));
      end
      pulse_clr();
      check($sformatf("vec%0d_clr", i), {parity_err, frame_err, overrun}, 0);
    end

    // Start-bit glitch is rejected, next frame still decodes
    uart_rxd = 1'b0;
    repeat (16) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_fill", fill, 0);
    check("glitch_flags", {parity_err, frame_err, overrun}, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    model_q.push_back(8'h5A);
    check("post_glitch_fill", fill, 1);
    pop_check("post_glitch");

    // Bad stop bit with the line held low, then recovery
    send_bits(frame_bits(8'hC3, 1'b0, 1'b0), 11);
    uart_rxd = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    check("break_ferr", frame_err, 1);
    check("break_fill", fill, 0);
    send_frame(8'h55, 1'b0, 1'b1);
    model_q.push_back(8'h55);
    check("after_break_fill", fill, 1);
    pop_check("after_break");
    pulse_clr();

    // Fill to overflow with no reads
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 37 + 11);
      model_frame(d, ^d, 1'b1, e_perr, e_ferr, e_ovr);
      send_frame(d, ^d, 1'b1);
      check($sformatf("ovf%0d_rts", i), uart_rts, (model_q.size() >= 12) ? 1 : 0);
    end
    first = 8'd11;
    check("ovf_fill", fill, 16);
    check("ovf_overrun", overrun, 1);
    check("ovf_head", rd_data, first);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_drain%0d", i));
    pulse_clr();

    // Asynchronous reset in the middle of a data field
    send_bits(frame_bits(8'h3C, 1'b0, 1'b1), 4);
    uart_rxd = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_fill", fill, 0);
    check("async_rst_valid", rd_valid, 0);
    check("async_rst_rts", uart_rts, 1);
    model_q.delete();
    uart_rxd = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1);
    model_q.push_back(8'h81);
    check("post_rst_fill", fill, 1);
    pop_check("post_rst");
    check("post_rst_empty", rd_valid, 0);

    // Randomized frames against the model
    for (int i = 0; i < 16; i++) begin
      int nrd;
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(3) == 0);
      s = ($urandom_range(5) != 0);
      pulse_clr();
      model_frame(d, p, s, e_perr, e_ferr, e_ovr);
      send_frame(d, p, s);
      check($sformatf("rnd%0d_fill", i), fill, model_q.size());
      check($sformatf("rnd%0d_flags", i), {parity_err, frame_err, overrun},
            {e_perr, e_ferr, e_ovr});
      nrd = $urandom_range(2);
      for (int k = 0; k < nrd; k++) begin
        if (model_q.size() > 0) pop_check($sformatf("rnd%0d_rd%0d", i, k));
      end
    end
    while (model_q.size() > 0) pop_check("final_drain");
    check("final_fill", fill, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
